// File: rtl/cache_line_fetcher_if.sv
// Bundle for the cache_line_fetcher: miss-request stream, line-response stream and AXI4 read channels.
// master is the fetcher's view; slave is the view of the way/fabric around it.
interface cache_line_fetcher_if #(
  parameter int TAGS_WIDTH = 48,
  parameter int CACHE_SIZE = 512,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  req_tvalid;
  logic                  req_tready;
  logic [TAGS_WIDTH-1:0] req_tdata;

  logic                  rsp_tvalid;
  logic                  rsp_tready;
  logic [CACHE_SIZE-1:0] rsp_tdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  req_tvalid, req_tdata, rsp_tready,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output req_tready, rsp_tvalid, rsp_tdata, rsp_err,
           m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output req_tvalid, req_tdata, rsp_tready,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  req_tready, rsp_tvalid, rsp_tdata, rsp_err,
           m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/cache_line_fetcher.sv
// Cache-line refill engine: one miss tag in, one AXI4 INCR read burst out, the assembled line back.
// A single fetch is outstanding at a time; beats are counted, rlast/rresp only feed the error flag.
module cache_line_fetcher #(
  parameter int                    TAGS_WIDTH = 48,
  parameter int                    CACHE_SIZE = 512,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_line_fetcher_if.master bus,
  output logic [31:0]          fetch_count
);
  localparam int         BEATS      = CACHE_SIZE / DATA_WIDTH;
  localparam int         LINE_BYTES = CACHE_SIZE / 8;
  localparam int         BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [7:0] ARLEN      = 8'(BEATS - 1);
  localparam logic [2:0] ARSIZE     = 3'($clog2(DATA_WIDTH / 8));

  if (BEATS > 256 || BEATS < 1 || (CACHE_SIZE % DATA_WIDTH) != 0) begin : g_bad_geometry
    $error("cache_line_fetcher: CACHE_SIZE must be a multiple of DATA_WIDTH giving 1..256 beats");
  end

  typedef enum logic [1:0] {IDLE, AR, R, RSP} state_t;

  state_t                state;
  logic                  idle_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  rsp_valid_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [BEAT_W-1:0]     beat;
  logic [CACHE_SIZE-1:0] line;
  logic [31:0]           count_q;
  logic                  last_beat;

  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  // NOTE: every register below is written with <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idle_q      <= 1'b1;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      araddr_q    <= '0;
      beat        <= '0;
      // NOTE: the line buffer is reset because rsp_tdata must read zero out of reset, not for correctness of a fetch.
      line        <= '0;
      count_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_tvalid) begin
            araddr_q  <= BASE_ADDR + ADDR_WIDTH'(bus.req_tdata) * ADDR_WIDTH'(LINE_BYTES);
            beat      <= '0;
            err_q     <= 1'b0;
            idle_q    <= 1'b0;
            arvalid_q <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (bus.m_axi_rvalid) begin
            line[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= bus.m_axi_rdata;
            // A misplaced or missing rlast is flagged but never shortens or extends the burst.
            if (bus.m_axi_rresp != 2'b00 || bus.m_axi_rlast != last_beat) err_q <= 1'b1;
            if (last_beat) begin
              rready_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              state       <= RSP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        RSP: begin
          if (bus.rsp_tready) begin
            rsp_valid_q <= 1'b0;
            idle_q      <= 1'b1;
            count_q     <= count_q + 32'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated with rst so the request stream is refused while reset is held.
  assign bus.req_tready    = idle_q && !rst;
  assign bus.rsp_tvalid    = rsp_valid_q;
  assign bus.rsp_tdata     = line;
  assign bus.rsp_err       = err_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = ARLEN;
  assign bus.m_axi_arsize  = ARSIZE;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;
  assign fetch_count       = count_q;
endmodule

// File: doc/cache_line_fetcher.md
# cache_line_fetcher

Backend refill engine for the LRU cache way. It accepts a miss tag on its request stream and issues one AXI4 INCR read burst covering the whole cache line. It assembles the returned beats into a single CACHE_SIZE-bit line and returns that line on its response stream. The block sits directly downstream of the way's backend address stream and directly upstream of its backend data stream, between the way and the memory/host AXI read fabric.

## Interface
- TAGS_WIDTH, 48, tag width; must equal the way's tag width.
- CACHE_SIZE, 512, cache line width in bits; multiple of DATA_WIDTH.
- DATA_WIDTH, 64, AXI read data width in bits; power of two, 8..CACHE_SIZE.
- ADDR_WIDTH, 64, AXI address width.
- BASE_ADDR, 64'h0, byte address of line 0.
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_tvalid  in  1  miss request valid.
- req_tready  out  1  request accepted when high with req_tvalid.
- req_tdata  in  TAGS_WIDTH  line tag to fetch.
- rsp_tvalid  out  1  assembled line valid.
- rsp_tready  in  1  consumer accepts line.
- rsp_tdata  out  CACHE_SIZE  assembled line.
- rsp_err  out  1  qualifies rsp_tvalid: a beat returned non-OKAY or rlast was misplaced.
- m_axi_araddr  out  ADDR_WIDTH  burst start address.
- m_axi_arlen  out  8  burst length minus one.
- m_axi_arsize  out  3  log2(DATA_WIDTH/8).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid / m_axi_arready  out / in  1  AR handshake.
- m_axi_rdata  in  DATA_WIDTH  read beat data.
- m_axi_rresp  in  2  beat response.
- m_axi_rlast  in  1  last beat marker.
- m_axi_rvalid / m_axi_rready  in / out  1  R handshake.
- fetch_count  out  32  completed-fetch counter.

## Operation
- Constants:
  - BEATS = CACHE_SIZE/DATA_WIDTH.
  - LINE_BYTES = CACHE_SIZE/8.
  - Elaboration error if BEATS > 256 or CACHE_SIZE % DATA_WIDTH ≠ 0.
- FSM states: IDLE, AR, R, RSP.
- IDLE:
  - req_tready=1.
  - On req_tvalid: latch araddr = BASE_ADDR + tag*LINE_BYTES, computed in ADDR_WIDTH bits with modulo wrap.
  - Clear beat counter and error flag; go to AR.
- AR:
  - m_axi_arvalid=1; arlen=BEATS-1.
  - araddr and arlen stay stable until m_axi_arready; then go to R.
- R:
  - m_axi_rready=1.
  - Each accepted beat k writes rdata into line[k*DATA_WIDTH +: DATA_WIDTH]; beat 0 is least significant.
  - Set the error flag if rresp≠2'b00 on any beat.
  - Set the error flag if rlast is high on a beat k<BEATS-1, or low on beat BEATS-1.
  - The burst ends on the counter, not on rlast: after beat BEATS-1, go to RSP.
- RSP:
  - rsp_tvalid=1; rsp_tdata and rsp_err are held stable until rsp_tready.
  - On the handshake: fetch_count+1 (wraps 2^32-1→0); go to IDLE.
- Only one fetch is outstanding at a time. req_tready=0 in AR, R and RSP.
- Error beats are still stored and the line is still delivered; error handling belongs to the consumer.

## Timing
- Reset values:
  - req_tready=0 during reset, 1 in the first cycle after reset.
  - rsp_tvalid=0, rsp_err=0, rsp_tdata=0.
  - m_axi_arvalid=0, m_axi_rready=0, m_axi_araddr=0, m_axi_arlen=BEATS-1, fetch_count=0; FSM in IDLE.
- Minimum latency, with arready and rvalid continuously high:
  - request handshake at cycle 0; arvalid at cycle 1.
  - beats at cycles 2..BEATS+1.
  - rsp_tvalid at cycle BEATS+2 (10 for the defaults).
- rsp_tready may be held high permanently; the block then returns to IDLE one cycle after rsp_tvalid rises.
- The next req_tready rises the cycle after the RSP handshake. There is no request/response overlap.
- rvalid gaps stall the counter with no data loss.
- arready low holds AR indefinitely.
- Reset mid-burst:
  - returns to IDLE next cycle; the partial line and error flag are discarded; fetch_count is cleared.
  - The AXI slave must be reset in the same domain. Stray R beats after reset are not accepted, because rready=0 in IDLE.
- rdata is captured only on the rvalid&&rready edge. rdata is not sampled in any other state.

## Test plan
- Defaults, tag=3, arready and rvalid always 1, beats 0x11..11×k for k=0..7, rlast on beat 7:
  - araddr=0xC0, arlen=7, arsize=3, arburst=1.
  - rsp_tvalid at cycle 10; rsp_tdata[63:0]=0, rsp_tdata[511:448]=0x7777777777777777.
  - rsp_err=0, fetch_count=1.
- arready held 0 for 5 cycles, rvalid toggling 1/0 per cycle, rsp_tready low 4 cycles after rsp_tvalid:
  - arvalid/araddr stable throughout; line correct.
  - rsp_tvalid/rsp_tdata held 4 cycles; req_tready=0 until after the handshake.
- Beat 4 returns rresp=2'b10:
  - full line still delivered, rsp_err=1.
  - Next fetch returns rsp_err=0.
- rlast asserted on beat 5:
  - burst still consumes 8 beats; rsp_err=1.
- rst asserted for one cycle at beat 3:
  - all outputs return to reset values the next cycle; fetch_count=0.
  - A new request tag=0 then returns araddr=0x0 with a clean line.
- Tag 0xFFFF_FFFF_FFFF, BASE_ADDR=0x1000:
  - araddr = (0x1000 + 0xFFFF_FFFF_FFFF*64) mod 2^64 = 0x40_0000_0000_0FC0.
- 2^32 completed fetches (preload the counter via force):
  - fetch_count wraps to 0.
